// File: rtl/mb_tx_serializer.sv
// ============================================================================
// mb_tx_serializer : UCIe 16-lane mainband transmit serializer.
// Buffers 64-byte flits and shifts each one out as 4 fragments of 8 UI.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mb_tx_serializer #(
  parameter int flit_buffer_size = 4
) (
  input  logic             periph_clkPins_i,
  input  logic             reset,
  input  logic             flit_valid_i,
  input  logic [63:0][7:0] flit_data_i,
  output logic             flit_ready_o,
  output logic             valid_oPin,
  output logic [15:0]      dataPins_o,
  output logic [1:0]       periph_clkPins_o,
  output logic             tx_idle_o
);

  localparam int AW = $clog2(flit_buffer_size);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(flit_buffer_size);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [63:0][7:0] mem [flit_buffer_size];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [0:0]       state;
  logic [2:0]       ui;
  logic [1:0]       frag;

  logic             push;
  logic             pop;
  logic             go;
  logic [2:0]       nxt_ui;
  logic [1:0]       nxt_frag;
  logic [5:0]       byte_idx;
  logic [15:0]      lanes;

  assign flit_ready_o = !reset && (count < DEPTH);
  assign push         = flit_valid_i && flit_ready_o;
  assign tx_idle_o    = (state == IDLE) && (count == '0);

  // ui/frag hold the position currently on the pins; nxt_* is what the
  // coming edge drives. In SEND the 5-bit position simply counts up and
  // wraps from frag 3 / UI 7 back to frag 0 / UI 0 of the next head entry.
  always_comb begin
    nxt_ui   = 3'd0;
    nxt_frag = 2'd0;
    go       = 1'b0;
    if (state == IDLE) begin
      go = (count != '0);
    end else begin
      {nxt_frag, nxt_ui} = {frag, ui} + 5'd1;
      go = !((frag == 2'd3) && (ui == 3'd7)) || (count != '0);
    end
  end

  assign pop = go && (nxt_frag == 2'd3) && (nxt_ui == 3'd7);

  always_comb begin
    lanes    = 16'h0;
    byte_idx = 6'd0;
    for (int b = 0; b < 16; b++) begin
      byte_idx = {nxt_frag, b[3:0]};
      lanes[b] = mem[rd_ptr][byte_idx][nxt_ui];
    end
  end

  // Flit storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge periph_clkPins_i) begin
    if (push) begin
      mem[wr_ptr] <= flit_data_i;
    end
  end

  always_ff @(posedge periph_clkPins_i) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge periph_clkPins_i) begin
    if (reset) begin
      state            <= IDLE;
      ui               <= 3'd0;
      frag             <= 2'd0;
      dataPins_o       <= 16'h0;
      valid_oPin       <= 1'b0;
      periph_clkPins_o <= 2'b00;
    end else if (go) begin
      state            <= SEND;
      ui               <= nxt_ui;
      frag             <= nxt_frag;
      dataPins_o       <= lanes;
      valid_oPin       <= !nxt_ui[2];
      periph_clkPins_o <= nxt_ui[0] ? 2'b10 : 2'b01;
    end else begin
      state            <= IDLE;
      ui               <= 3'd0;
      frag             <= 2'd0;
      dataPins_o       <= 16'h0;
      valid_oPin       <= 1'b0;
      periph_clkPins_o <= 2'b00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mb_tx_serializer.sv
// ============================================================================
// tb_mb_tx_serializer : directed bench for mb_tx_serializer with a pin
// monitor and a reference deserializer that rebuilds flits from the lanes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mb_tx_serializer;

  logic             clk;
  logic             reset;
  logic             flit_valid;
  logic [63:0][7:0] flit_data;
  logic             flit_ready;
  logic             valid_pin;
  logic [15:0]      data_pins;
  logic [1:0]       clk_pins;
  logic             tx_idle;

  mb_tx_serializer #(.flit_buffer_size(4)) dut (
    .periph_clkPins_i (clk),
    .reset            (reset),
    .flit_valid_i     (flit_valid),
    .flit_data_i      (flit_data),
    .flit_ready_o     (flit_ready),
    .valid_oPin       (valid_pin),
    .dataPins_o       (data_pins),
    .periph_clkPins_o (clk_pins),
    .tx_idle_o        (tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic [1:0]  strb;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        v;
    logic [1:0]  s;
    int          cyc;
  } ui_t;

  int n_checks = 0;
  int n_pass   = 0;
  ui_t ui_q[$];
  logic [63:0][7:0] exp_q[$];
  int mon_cyc = 0;

  // Every UI that carries a strobe is captured for the reference deserializer.
  always @(negedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (!reset && clk_pins != 2'b00)
      ui_q.push_back('{data_pins, valid_pin, clk_pins, mon_cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0][7:0] fill(input logic [7:0] b);
    logic [63:0][7:0] f;
    for (int k = 0; k < 64; k++) f[k] = b;
    return f;
  endfunction

  function automatic logic [63:0][7:0] rnd_flit();
    logic [63:0][7:0] f;
    for (int k = 0; k < 64; k++) f[k] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (tx_idle) break;
      tick();
    end
    chk("wait_idle_timeout", 32'(i < bound), 32'd1);
  endtask

  // Rebuild flits from the captured lanes and compare with the queued flits.
  task automatic check_stream(input int nflits);
    logic [63:0][7:0] got;
    logic [63:0][7:0] exp;
    ui_t e;
    int bad, ferr, gaps;
    chk("stream_len", 32'(ui_q.size()), 32'(nflits * 32));
    if (ui_q.size() != nflits * 32 || exp_q.size() < nflits) return;
    gaps = 0;
    for (int i = 1; i < ui_q.size(); i++)
      if (ui_q[i].cyc != ui_q[i-1].cyc + 1) gaps++;
    chk("stream_contiguous_gaps", 32'(gaps), 32'd0);
    for (int f = 0; f < nflits; f++) begin
      got  = '0;
      ferr = 0;
      for (int h = 0; h < 4; h++)
        for (int u = 0; u < 8; u++) begin
          e = ui_q[f*32 + h*8 + u];
          for (int b = 0; b < 16; b++) got[h*16+b][u] = e.d[b];
          if (e.v !== (u < 4) || e.s !== ((u % 2) ? 2'b10 : 2'b01)) ferr++;
        end
      exp = exp_q.pop_front();
      bad = 0;
      for (int k = 0; k < 64; k++) if (got[k] !== exp[k]) bad++;
      chk($sformatf("flit%0d_bad_bytes", f), 32'(bad), 32'd0);
      chk($sformatf("flit%0d_framing_errs", f), 32'(ferr), 32'd0);
    end
  endtask

  // Lane patterns for byte k = k: bits 0..3 repeat per fragment, bits 4/5
  // follow the fragment's upper byte-index bits.
  logic [15:0] dtab [32] = '{
    16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
    16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000,
    16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000
  };
  vec_t vecs [32];

  initial begin
    int n_acc, c0, c4, nr;
    logic rdy;
    logic [63:0][7:0] cur;

    for (int i = 0; i < 32; i++)
      vecs[i] = '{dtab[i], ((i % 8) < 4), ((i % 2) ? 2'b10 : 2'b01)};

    reset      = 1'b1;
    flit_valid = 1'b0;
    flit_data  = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_valid", 32'(valid_pin), 32'd0);
    chk("rst_data", 32'(data_pins), 32'd0);
    chk("rst_strobe", 32'(clk_pins), 32'd0);
    chk("rst_idle", 32'(tx_idle), 32'd1);
    chk("rst_ready", 32'(flit_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(flit_ready), 32'd1);
    chk("post_rst_idle", 32'(tx_idle), 32'd1);

    // Single flit, byte k = k
    for (int k = 0; k < 64; k++) flit_data[k] = 8'(k);
    flit_valid = 1'b1;
    tick();
    flit_valid = 1'b0;
    chk("single_pre_strobe", 32'(clk_pins), 32'd0);
    chk("single_busy", 32'(tx_idle), 32'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("single_ui%0d_data", i), 32'(data_pins), 32'(vecs[i].data));
      chk($sformatf("single_ui%0d_valid", i), 32'(valid_pin), 32'(vecs[i].valid));
      chk($sformatf("single_ui%0d_strobe", i), 32'(clk_pins), 32'(vecs[i].strb));
      tick();
    end
    chk("single_end_data", 32'(data_pins), 32'd0);
    chk("single_end_strobe", 32'(clk_pins), 32'd0);
    chk("single_end_valid", 32'(valid_pin), 32'd0);
    chk("single_end_idle", 32'(tx_idle), 32'd1);
    ui_q.delete();

    // Back-to-back A, B, C
    flit_valid = 1'b1;
    flit_data = fill(8'h11); exp_q.push_back(flit_data); tick();
    flit_data = fill(8'h22); exp_q.push_back(flit_data); tick();
    flit_data = fill(8'h33); exp_q.push_back(flit_data); tick();
    flit_valid = 1'b0;
    wait_idle(200);
    if (ui_q.size() >= 33) begin
      chk("ab_last_strobe", 32'(ui_q[31].s), 32'h2);
      chk("ab_last_valid", 32'(ui_q[31].v), 32'd0);
      chk("ab_first_strobe", 32'(ui_q[32].s), 32'h1);
      chk("ab_first_valid", 32'(ui_q[32].v), 32'd1);
      chk("ab_adjacent", 32'(ui_q[32].cyc - ui_q[31].cyc), 32'd1);
    end
    check_stream(3);
    ui_q.delete();
    exp_q.delete();

    // FIFO full with flit_valid held high
    n_acc = 0; c0 = 0; c4 = 0; nr = 0;
    for (int i = 0; i < 100 && n_acc < 5; i++) begin
      flit_data  = fill(8'h40 + 8'(n_acc));
      flit_valid = 1'b1;
      rdy = flit_ready;
      if (rdy) begin
        if (n_acc == 0) c0 = i;
        if (n_acc == 4) c4 = i;
        exp_q.push_back(flit_data);
        n_acc++;
      end else begin
        nr++;
      end
      tick();
      if (rdy && n_acc == 4) chk("full_ready_drop", 32'(flit_ready), 32'd0);
    end
    flit_valid = 1'b0;
    chk("full_accepts", 32'(n_acc), 32'd5);
    chk("full_reopen_edge", 32'(c4 - c0), 32'd33);
    chk("full_blocked_cycles", 32'(nr), 32'd29);
    wait_idle(400);
    check_stream(5);
    ui_q.delete();
    exp_q.delete();

    // Reset at frag 2 / UI 3 with two flits queued behind
    flit_valid = 1'b1;
    flit_data = fill(8'h5A); tick();
    flit_data = fill(8'h6B); tick();
    flit_data = fill(8'h7C); tick();
    flit_valid = 1'b0;
    repeat (18) tick();
    chk("mid_f2u3_data", 32'(data_pins), 32'hFFFF);
    chk("mid_f2u3_valid", 32'(valid_pin), 32'd1);
    chk("mid_f2u3_strobe", 32'(clk_pins), 32'h2);
    reset = 1'b1;
    tick();
    chk("mid_rst_data", 32'(data_pins), 32'd0);
    chk("mid_rst_valid", 32'(valid_pin), 32'd0);
    chk("mid_rst_strobe", 32'(clk_pins), 32'd0);
    chk("mid_rst_count", 32'(dut.count), 32'd0);
    chk("mid_rst_idle", 32'(tx_idle), 32'd1);
    ui_q.delete();
    reset = 1'b0;
    tick();
    chk("mid_rel_ready", 32'(flit_ready), 32'd1);
    flit_data  = rnd_flit();
    flit_valid = 1'b1;
    exp_q.push_back(flit_data);
    tick();
    flit_valid = 1'b0;
    wait_idle(100);
    check_stream(1);
    ui_q.delete();
    exp_q.delete();

    // Pointer wrap: 9 random flits
    n_acc = 0;
    cur = rnd_flit();
    for (int i = 0; i < 1000 && n_acc < 9; i++) begin
      flit_data  = cur;
      flit_valid = 1'b1;
      rdy = flit_ready;
      tick();
      if (rdy) begin
        exp_q.push_back(cur);
        n_acc++;
        cur = rnd_flit();
      end
    end
    flit_valid = 1'b0;
    chk("wrap_accepts", 32'(n_acc), 32'd9);
    wait_idle(600);
    check_stream(9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
